// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and data access,
//            with bounded fetch starvation, access timeout and pipeline stall.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int TIMEOUT       = 64,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          pipe_stall,
  output logic          bus_err
);

  localparam int c_WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int c_SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [c_WW-1:0] c_TO_LAST    = c_WW'(TIMEOUT - 1);
  localparam logic [c_SW-1:0] c_STREAK_MAX = c_SW'(MAX_DM_STREAK);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IF_ACC = 2'd1,
    S_DM_ACC = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_WW-1:0] r_wait_cnt;
  logic [c_SW-1:0] r_streak;

  logic w_grant_dm;
  logic w_finish;

  // Data wins unless the waiting fetch has already lost MAX_DM_STREAK times.
  assign w_grant_dm = dm_req & ~(if_req & (r_streak == c_STREAK_MAX));
  // An ack on the last allowed cycle still counts as a successful access.
  assign w_finish   = mem_ack | (r_wait_cnt == c_TO_LAST);
  assign pipe_stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_streak   <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (if_req || dm_req) begin
            r_wait_cnt <= '0;
            mem_cs     <= 1'b1;
            if (w_grant_dm) begin
              r_state   <= S_DM_ACC;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              if (!if_req) begin
                r_streak <= '0;
              end else if (r_streak != c_STREAK_MAX) begin
                r_streak <= r_streak + 1'b1;
              end
            end else begin
              r_state   <= S_IF_ACC;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              r_streak  <= '0;
            end
          end
        end
        S_IF_ACC, S_DM_ACC: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (w_finish) begin
            r_state <= S_DONE;
            mem_cs  <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_ack) begin
              bus_err <= 1'b1;
            end
            if (r_state == S_DM_ACC) begin
              dm_ready <= 1'b1;
              dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the single unified memory port of the 5-stage MIPS pipeline between the IF stage (instruction fetch) and the MEM stage (lw/sw data access). It sequences one access at a time through a four-state FSM, prioritises data over fetch with a bounded-starvation rule, guards every access with a timeout watchdog, and generates the pipeline-wide stall. It sits between the IF/MEM stage logic and the memory model; the control unit's MemWrite feeds `dm_we`.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 64, max cycles an access may wait for `mem_ack` (≥2)
- `MAX_DM_STREAK`, 4, consecutive data grants allowed while a fetch waits (≥1)

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `if_req`  in  1  fetch request, level, held until `if_ready`
- `if_addr`  in  AW  fetch address
- `if_rdata`  out  DW  fetched word, valid while `if_ready`=1
- `if_ready`  out  1  one-cycle completion pulse to IF
- `dm_req`  in  1  data request, level, held until `dm_ready`
- `dm_we`  in  1  1=store (sw), 0=load (lw)
- `dm_addr`  in  AW  data address
- `dm_wdata`  in  DW  store data
- `dm_rdata`  out  DW  load data, valid while `dm_ready`=1
- `dm_ready`  out  1  one-cycle completion pulse to MEM
- `mem_cs`  out  1  memory chip select, held for whole access
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  one-cycle completion from memory
- `pipe_stall`  out  1  stall all pipeline registers
- `bus_err`  out  1  sticky timeout flag

## Operation
- States: IDLE, IF_ACC, DM_ACC, DONE.
- IDLE: if no request, stay. If requests present, grant by rule below; register address/data/we of the winner into `mem_*`, go to IF_ACC or DM_ACC.
- Grant rule: `dm_req` wins over `if_req`, except when `streak`==MAX_DM_STREAK and `if_req`=1, then IF wins. `streak` increments (saturating) on each DM grant made while `if_req`=1; clears on any IF grant or on any DM grant with `if_req`=0.
- IF_ACC / DM_ACC: `mem_cs`=1, `mem_*` stable. `wait_cnt` increments each cycle. On `mem_ack`: capture `mem_rdata` into `if_rdata`/`dm_rdata` (for stores `dm_rdata` = 0), go DONE. If `wait_cnt` reaches TIMEOUT-1 without ack: drop access, rdata := 0, set `bus_err`, go DONE.
- DONE: pulse the owner's ready for exactly this cycle; `mem_cs`=0; no new grant; next state IDLE. Requester drops or re-presents req next cycle.
- `mem_ack` outside IF_ACC/DM_ACC is ignored.
- `pipe_stall` = (`if_req` & ~`if_ready`) | (`dm_req` & ~`dm_ready`), combinational.
- `bus_err` stays 1 until reset.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, `mem_cs`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `if_rdata`=0, `dm_rdata`=0, `if_ready`=0, `dm_ready`=0, `bus_err`=0, `streak`=0, `wait_cnt`=0. Reset mid-access aborts it with no ready pulse; `pipe_stall` follows inputs.
- Request sampled at edge of cycle 0 → `mem_cs`=1 in cycle 1 → ack in cycle k (k≥1) → ready pulse in cycle k+1 → IDLE in cycle k+2. Minimum turnaround 3 cycles per access.
- Timeout: with no ack, `mem_cs` high cycles 1..TIMEOUT; DONE (ready pulse, `bus_err`=1) in cycle TIMEOUT+1.
- Ack in the same cycle the timeout fires counts as success; `bus_err` not set.
- Simultaneous `if_req`,`dm_req` in IDLE: exactly one grant; the loser stays pending, granted no earlier than the following IDLE.
- Request inputs changing while not in IDLE have no effect on the in-flight access.
- `wait_cnt` clears on entry to any ACC state.

## Test plan
- Single load: `dm_req`=1, `dm_we`=0, addr 0x40, memory acks 2 cycles after cs with 0x1234_5678 → `dm_ready` pulse one cycle after ack, `dm_rdata`=0x1234_5678, `pipe_stall` 1 until then.
- Conflict: `if_req` and `dm_req` both raised in cycle 0 → DM access first (`mem_addr`=dm_addr), IF access starts in cycle after DM's DONE+IDLE.
- Starvation: `dm_req` held continuously with new requests, `if_req` held, MAX_DM_STREAK=4 → exactly 4 DM grants, then IF grant, then `streak` reset.
- Store: `dm_we`=1, addr 0x80, wdata 0xCAFE_F00D → `mem_we`=1, `mem_wdata`=0xCAFE_F00D throughout access, `dm_rdata`=0 with `dm_ready`.
- Timeout: TIMEOUT=8, never ack → `mem_cs` high 8 cycles, `if_ready` pulse with `if_rdata`=0, `bus_err`=1 sticky; late ack afterwards ignored.
- Reset mid-access: `rst_n`=0 during DM_ACC → next cycle all outputs at reset values, no ready pulse, `bus_err`=0.
